// File: rtl/rib_dma_master.sv
// rib_dma_master: word-copy DMA engine acting as a RIB bus initiator.
// A small register port (SRC, DST, LEN, CTRL/STATUS) configures a copy that
// alternates read and write beats until LEN words have moved or an abort lands.
// Optional build macro: RIB_DMA_IRQ_EN adds irq_o and the CTRL IRQ_MASK bit.
module rib_dma_master #(
   parameter int LEN_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we_i,
   input  logic [3:0]  cfg_addr_i,
   input  logic [31:0] cfg_data_i,
   output logic [31:0] cfg_data_o,
   output logic        m_req_o,
   output logic        m_we_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_data_o,
   input  logic [31:0] m_data_i,
   input  logic        m_ack_i
`ifdef RIB_DMA_IRQ_EN
   ,
   output logic        irq_o
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

   state_t             state;
   state_t             state_nx;
   logic [31:0]        src;
   logic [31:0]        dst;
   logic [LEN_W-1:0]   len;
   logic               done;
   logic               aborted;
   logic               irq_mask;
   logic [31:0]        src_ptr;
   logic [31:0]        dst_ptr;
   logic [LEN_W-1:0]   cnt;
   logic [31:0]        buffer;
   logic               abort_flag;

   logic               busy;
   logic               wr_src;
   logic               wr_dst;
   logic               wr_len;
   logic               wr_ctrl;
   logic               start;
   logic               abort_req;
   logic               abort_any;
   logic               unused_bits;

   assign busy      = (state != IDLE);
   assign wr_src    = cfg_we_i && (cfg_addr_i[3:2] == 2'd0);
   assign wr_dst    = cfg_we_i && (cfg_addr_i[3:2] == 2'd1);
   assign wr_len    = cfg_we_i && (cfg_addr_i[3:2] == 2'd2);
   assign wr_ctrl   = cfg_we_i && (cfg_addr_i[3:2] == 2'd3);
   assign start     = wr_ctrl && cfg_data_i[0] && !busy;
   // An abort only means something while a transfer is running.
   assign abort_req = wr_ctrl && cfg_data_i[3] && busy;
   // A request arriving on the very edge that completes a beat is honoured too.
   assign abort_any = abort_flag || abort_req;

`ifdef RIB_DMA_IRQ_EN
   assign unused_bits = ^{cfg_data_i[1], cfg_addr_i[1:0]};
   assign irq_o       = (done || aborted) && !irq_mask;
`else
   assign unused_bits = ^{cfg_data_i[5], cfg_data_i[1], cfg_addr_i[1:0]};
`endif

   // State register of the copy sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: each beat advances only on its ack.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start && (len != {LEN_W{1'b0}})) state_nx = RD;
            else                                 state_nx = IDLE;
         end
         RD: begin
            if (m_ack_i) state_nx = abort_any ? FIN : WR;
            else         state_nx = RD;
         end
         WR: begin
            if (m_ack_i) state_nx = (abort_any || (cnt == LEN_W'(1))) ? FIN : RD;
            else         state_nx = WR;
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Bus outputs come straight from state and held registers, so they stay put while waiting.
   always_comb begin
      m_req_o  = 1'b0;
      m_we_o   = 1'b0;
      m_addr_o = 32'd0;
      m_data_o = 32'd0;
      case (state)
         RD: begin
            m_req_o  = 1'b1;
            m_addr_o = src_ptr;
         end
         WR: begin
            m_req_o  = 1'b1;
            m_we_o   = 1'b1;
            m_addr_o = dst_ptr;
            m_data_o = buffer;
         end
         default: begin
            m_req_o  = 1'b0;
         end
      endcase
   end

   // Configuration registers, sticky status and the working copies of the transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src        <= 32'd0;
         dst        <= 32'd0;
         len        <= {LEN_W{1'b0}};
         done       <= 1'b0;
         aborted    <= 1'b0;
         irq_mask   <= 1'b0;
         src_ptr    <= 32'd0;
         dst_ptr    <= 32'd0;
         cnt        <= {LEN_W{1'b0}};
         buffer     <= 32'd0;
         abort_flag <= 1'b0;
      end else begin
         if (wr_src && !busy) src <= {cfg_data_i[31:2], 2'b00};
         if (wr_dst && !busy) dst <= {cfg_data_i[31:2], 2'b00};
         if (wr_len && !busy) len <= cfg_data_i[LEN_W-1:0];
         // Write-one-to-clear first; any set further down overrides it.
         if (wr_ctrl && cfg_data_i[2]) done    <= 1'b0;
         if (wr_ctrl && cfg_data_i[4]) aborted <= 1'b0;
`ifdef RIB_DMA_IRQ_EN
         if (wr_ctrl) irq_mask <= cfg_data_i[5];
`endif
         if (abort_req) abort_flag <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  aborted    <= 1'b0;
                  abort_flag <= 1'b0;
                  if (len == {LEN_W{1'b0}}) begin
                     done <= 1'b1;
                  end else begin
                     done    <= 1'b0;
                     src_ptr <= src;
                     dst_ptr <= dst;
                     cnt     <= len;
                  end
               end
            end
            RD: begin
               if (m_ack_i) begin
                  buffer  <= m_data_i;
                  src_ptr <= src_ptr + 32'd4;
               end
            end
            WR: begin
               if (m_ack_i) begin
                  dst_ptr <= dst_ptr + 32'd4;
                  cnt     <= cnt - LEN_W'(1);
               end
            end
            FIN: begin
               if (abort_flag) aborted <= 1'b1;
               else            done    <= 1'b1;
               abort_flag <= 1'b0;
            end
            default: begin
               abort_flag <= 1'b0;
            end
         endcase
      end
   end

   // Register read mux; START and ABORT are strobes and always read as zero.
   always_comb begin
      cfg_data_o = 32'd0;
      case (cfg_addr_i[3:2])
         2'd0:    cfg_data_o = src;
         2'd1:    cfg_data_o = dst;
         2'd2:    cfg_data_o = {{(32-LEN_W){1'b0}}, len};
         2'd3:    cfg_data_o = {26'd0, irq_mask, aborted, 1'b0, done, busy, 1'b0};
         default: cfg_data_o = 32'd0;
      endcase
   end

endmodule

// File: doc/rib_dma_master.md
Name: rib_dma_master

Overview:
- Word-copy DMA engine and RIB bus initiator: reads words from a source address, writes them to a destination address.
- Configured via a small register port driven by the core; issues req/we/addr/data and waits for ack_i from responders (ram, peripherals).
- Sits beside the core on the RIB interconnect as an additional master.
- Interconnect arbitration is external; the block only drives a request and waits.

Parameters:
- LEN_W, 16, width of the word-count register (max transfer 2^LEN_W-1 words).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cfg_we_i  in  1  config write enable
- cfg_addr_i  in  4  config byte address; bits [3:2] select register
- cfg_data_i  in  32  config write data
- cfg_data_o  out  32  config read data, combinational from cfg_addr_i
- m_req_o  out  1  bus request
- m_we_o  out  1  1 = write beat, 0 = read beat
- m_addr_o  out  32  bus address, always word-aligned
- m_data_o  out  32  bus write data
- m_data_i  in  32  bus read data, valid when m_ack_i=1
- m_ack_i  in  1  beat completion from responder

Behaviour:
- Registers:
  - 0x0 SRC, 0x4 DST (bits [1:0] read as 0, writes forced to 0).
  - 0x8 LEN (LEN_W bits, zero-extended on read).
  - 0xC CTRL/STATUS: bit0 START (write 1, reads 0); bit1 BUSY (RO); bit2 DONE (sticky, write 1 clears); bit3 ABORT (write 1 requests abort, reads 0); bit4 ABORTED (sticky, write 1 clears).
- Reset: all registers 0, FSM IDLE, m_req_o=0, m_we_o=0, m_addr_o=0, m_data_o=0.
- Writes to SRC/DST/LEN while BUSY=1 are ignored; START while BUSY=1 is ignored.
- START with LEN=0: DONE=1 on the next cycle, no bus traffic, BUSY never asserted.
- FSM states IDLE, RD, WR, FIN:
  - IDLE -> RD on START with LEN!=0. Working copies latched: src_ptr=SRC, dst_ptr=DST, cnt=LEN. DONE and ABORTED cleared.
  - RD: m_req_o=1, m_we_o=0, m_addr_o=src_ptr. On a clk edge with m_ack_i=1: capture m_data_i into buffer, src_ptr+=4, go WR.
  - WR: m_req_o=1, m_we_o=1, m_addr_o=dst_ptr, m_data_o=buffer. On ack: dst_ptr+=4, cnt-=1. Go RD if cnt-1!=0 and no pending abort, else FIN.
  - FIN: m_req_o=0 for one cycle. Set DONE, or set ABORTED instead if the abort flag is set. Then IDLE.
- BUSY=1 in RD/WR/FIN.
- Handshake: once raised, m_req_o, m_we_o, m_addr_o and m_data_o are held stable until the cycle m_ack_i=1. The beat completes on that edge. Same-cycle ack (combinational responder such as ram) is legal: one beat per cycle minimum. m_ack_i while m_req_o=0 is ignored.
- Abort: latched internally. The current beat always completes. An abort raised in RD still completes that read, then goes to FIN with no write. An abort in WR goes to FIN after the ack.
- Pointers wrap modulo 2^32 with no error. SRC/DST overlap is not detected; copy proceeds in ascending order.
- Reset asserted mid-transfer: immediate return to reset values, m_req_o drops asynchronously.
- Simultaneous W1C of DONE and FIN setting DONE: set wins.

Optional Feature:
- Macro RIB_DMA_IRQ_EN.
- Defined: extra port irq_o (out, 1) = DONE | ABORTED, level, cleared by W1C. Also adds CTRL bit5 IRQ_MASK (R/W, reset 0); when 1, irq_o is forced 0.
- Undefined: no irq_o port, bit5 reads 0, writes ignored.

Test Plan:
- Zero-wait copy: SRC=0x100, DST=0x200, LEN=4, same-cycle ack responder. Response: 8 beats alternating R/W, addrs 0x100,0x200,0x104,...,0x20C; DONE=1 two cycles after last write ack.
- Wait states: responder acks 3 cycles after req. Response: addr/we/data held constant through all waits; data at 0x200 equals data at 0x100.
- LEN=0 START: next cycle DONE=1, BUSY=0; m_req_o never asserted.
- Abort during a read beat with LEN=10: read completes, no write follows; ABORTED=1, DONE=0, m_req_o=0.
- Config write during busy: write SRC=0xDEAD0000 mid-transfer. Response: SRC reads original value; transfer addresses unaffected; second START ignored.
- Async reset mid-WR: m_req_o=0 before the next clk edge; all registers 0; new START after release works.
